mult_seq32: RTL

Sequential 32×32 → 64-bit unsigned shift-and-add multiplier built around one instance of the team's 32-bit ripple-carry adder. It sits directly downstream of the adder and is its first multi-cycle consumer. It iterates one multiplier bit per clock, using a start/ready/done handshake, so the datapath needs only a single adder.

---
 rtl/mult_seq32_pkg.sv | 16 +
 rtl/mult_seq32_if.sv | 23 ++
 rtl/mult_seq32_fa.sv | 27 ++
 rtl/mult_seq32.sv | 87 ++++++++
 4 files changed

// File: rtl/mult_seq32_pkg.sv
// Shared definitions for the sequential 32x32 -> 64 shift-and-add multiplier.
//   MUL_W   : operand width; the product is 2*MUL_W bits wide
//   CNT_W   : iteration counter width (one iteration per multiplier bit)
//   state_t : controller state encoding
package mult_seq32_pkg;

   localparam int unsigned MUL_W = 32;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : mult_seq32_pkg

// File: rtl/mult_seq32_if.sv
// Handshake and data bundle for mult_seq32.
//   start   : request a multiply; only sampled while ready is high
//   a, b    : multiplicand / multiplier, captured on the accepting edge
//   ready   : controller idle, able to accept
//   busy    : iterating
//   done    : one-cycle pulse, product valid
//   product : 64-bit result, held until the next accept
// master = requester side, slave = multiplier side.
interface mult_seq32_if;
   import mult_seq32_pkg::*;

   logic                   start;
   logic [MUL_W-1:0]       a;
   logic [MUL_W-1:0]       b;
   logic                   ready;
   logic                   busy;
   logic                   done;
   logic [2*MUL_W-1:0]     product;

   modport master (output start, a, b, input ready, busy, done, product);
   modport slave  (input start, a, b, output ready, busy, done, product);

endinterface : mult_seq32_if

// File: rtl/mult_seq32_fa.sv
// fa_32: 32-bit ripple-carry adder.
//   a_i, b_i : addends
//   c_in_i   : carry in
//   sum_o    : 32-bit sum
//   c_out_o  : carry out of bit 31
module fa_32 (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        c_in_i,
   output logic [31:0] sum_o,
   output logic        c_out_o
);

   // The carry is a block-local variable so the chain is a single ripple
   // through one process instead of a self-referencing carry vector.
   always_comb begin
      logic carry;
      sum_o = '0;
      carry = c_in_i;
      for (int i = 0; i < 32; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
         carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
      c_out_o = carry;
   end

endmodule : fa_32

// File: rtl/mult_seq32.sv
// mult_seq32: sequential unsigned 32x32 -> 64 shift-and-add multiplier.
// One multiplier bit is consumed per clock through a single 32-bit adder;
// 32 iterations per operation, no early exit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mult_seq32_if.slave (start/a/b in, ready/busy/done/product out)
//
// state   | meaning
// --------+--------------------------------------------------
// ST_IDLE | waiting for start; ready high
// ST_RUN  | one add/shift iteration per edge; busy high
// ST_DONE | single cycle; done high, product final
module mult_seq32
   import mult_seq32_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   mult_seq32_if.slave   bus
);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2*MUL_W-1:0]    p_q, p_d;
   logic [MUL_W-1:0]      mcand_q, mcand_d;

   logic [MUL_W-1:0]      sum;
   logic                  c_out;

   // Upper half of P accumulates the partial product; the lower half holds
   // the not-yet-consumed multiplier bits, shifting out through P[0].
   fa_32 u_add (
      .a_i     (p_q[2*MUL_W-1:MUL_W]),
      .b_i     (mcand_q),
      .c_in_i  (1'b0),
      .sum_o   (sum),
      .c_out_o (c_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         mcand_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         mcand_q <= mcand_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      mcand_d = mcand_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               mcand_d = bus.a;
               p_d     = {{MUL_W{1'b0}}, bus.b};
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Carry-out lands in bit 63, so the 64-bit result never overflows.
            if (p_q[0])
               p_d = {c_out, sum, p_q[MUL_W-1:1]};
            else
               p_d = {1'b0, p_q[2*MUL_W-1:MUL_W], p_q[MUL_W-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MUL_W - 1))
               state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.ready   = (state_q == ST_IDLE);
   assign bus.busy    = (state_q == ST_RUN);
   assign bus.done    = (state_q == ST_DONE);
   assign bus.product = p_q;

endmodule : mult_seq32
